// File: rtl/jtframe_dwnld_pack.sv
// Packs the HPS byte download stream into SDRAM programming writes.
// A small FIFO absorbs SDRAM write latency; each head byte is decoded into bank, word address and lane mask.
module jtframe_dwnld_pack #(
  parameter logic [22:0] BA1_START = 23'h10_0000,
  parameter logic [22:0] BA2_START = 23'h30_0000,
  parameter logic [22:0] BA3_START = 23'h50_0000,
  parameter int          FIFO_AW   = 2,
  parameter bit          SWAB      = 1'b0
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [22:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_rom_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        dwnld_busy,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t               state;
  logic [30:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count;
  logic                 empty, full, push, pop, drop;
  logic                 downloading_last;
  logic [22:0]          head_addr, offset;
  logic [7:0]           head_data;
  logic [1:0]           bank, lane, mask;

  assign empty = (count == '0);
  // count can only reach DEPTH, so its MSB alone marks a full FIFO
  assign full  = count[FIFO_AW];
  assign pop   = (state == WRITE) && prog_rdy;
  assign push  = ioctl_rom_wr && (!full || pop);
  assign drop  = ioctl_rom_wr && !push;

  assign {head_addr, head_data} = mem[rd_ptr];

  always_comb begin
    bank   = 2'd0;
    offset = head_addr;
    if (head_addr >= BA3_START) begin
      bank   = 2'd3;
      offset = head_addr - BA3_START;
    end else if (head_addr >= BA2_START) begin
      bank   = 2'd2;
      offset = head_addr - BA2_START;
    end else if (head_addr >= BA1_START) begin
      bank   = 2'd1;
      offset = head_addr - BA1_START;
    end
    lane = offset[0] ? 2'b01 : 2'b10;
    mask = SWAB ? ~lane : lane;
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= {ioctl_addr, ioctl_data};
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state     <= IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_bank <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          prog_addr <= offset[22:1];
          prog_data <= head_data;
          prog_mask <= mask;
          prog_bank <= bank;
          prog_we   <= 1'b1;
          state     <= WRITE;
        end
        WRITE: if (prog_rdy) begin
          prog_we <= 1'b0;
          state   <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      overflow         <= 1'b0;
      dwnld_busy       <= 1'b0;
      downloading_last <= 1'b0;
    end else begin
      downloading_last <= downloading;
      dwnld_busy       <= downloading || !empty || (state != IDLE);
      // a drop in the same cycle as a new download start still gets flagged
      if (downloading && !downloading_last) overflow <= 1'b0;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Bench for jtframe_dwnld_pack: directed scenarios plus random traffic,
// checked every cycle against a queue-based timing model.
module tb_jtframe_dwnld_pack;

  localparam int          DEPTH = 4;
  localparam logic [22:0] BA1 = 23'h10_0000;
  localparam logic [22:0] BA2 = 23'h30_0000;
  localparam logic [22:0] BA3 = 23'h50_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [22:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_rom_wr = 1'b0;
  logic        prog_rdy = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask, prog_bank;
  logic        prog_we, dwnld_busy, overflow;

  jtframe_dwnld_pack dut (
    .clk_sys(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_rom_wr(ioctl_rom_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_bank(prog_bank), .prog_we(prog_we), .prog_rdy(prog_rdy),
    .dwnld_busy(dwnld_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [22:0] a; logic [7:0] d; } ent_t;
  ent_t        q[$];
  bit          started = 0;
  longint      cyc = 0;
  bit          m_req = 0;          // a write request is outstanding
  longint      m_idle_from = 0;    // first cycle a new request may be decided
  logic [21:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [1:0]  m_mask = 2'b11, m_bank = '0;
  bit          m_busy = 0, m_ovf = 0, m_dl_last = 0;

  function automatic void decode(input logic [22:0] a, output logic [1:0] b,
                                 output logic [21:0] w, output logic [1:0] m);
    logic [22:0] off;
    if (a >= BA3)      begin b = 2'd3; off = a - BA3; end
    else if (a >= BA2) begin b = 2'd2; off = a - BA2; end
    else if (a >= BA1) begin b = 2'd1; off = a - BA1; end
    else               begin b = 2'd0; off = a; end
    w = 22'(off / 2);
    m = (off % 2 == 1) ? 2'b01 : 2'b10;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      started = 1;
      q.delete();
      m_req = 0; m_idle_from = 0;
      m_addr = '0; m_data = '0; m_mask = 2'b11; m_bank = '0;
      m_busy = 0; m_ovf = 0; m_dl_last = 0;
    end else begin
      bit pop, push, nb;
      nb   = downloading || (q.size() > 0) || m_req || (cyc < m_idle_from);
      pop  = m_req && prog_rdy;
      if (!m_req && cyc >= m_idle_from && q.size() > 0) begin
        decode(q[0].a, m_bank, m_addr, m_mask);
        m_data = q[0].d;
        m_req  = 1;
      end
      push = ioctl_rom_wr && (q.size() < DEPTH || pop);
      if (downloading && !m_dl_last) m_ovf = 0;
      if (ioctl_rom_wr && !push) m_ovf = 1;
      if (pop) begin
        void'(q.pop_front());
        m_req = 0;
        m_idle_from = cyc + 2;
      end
      if (push) q.push_back({ioctl_addr, ioctl_data});
      m_busy = nb;
      m_dl_last = downloading;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_we",   32'(prog_we),    32'(m_req));
      check("m_addr", 32'(prog_addr),  32'(m_addr));
      check("m_data", 32'(prog_data),  32'(m_data));
      check("m_mask", 32'(prog_mask),  32'(m_mask));
      check("m_bank", 32'(prog_bank),  32'(m_bank));
      check("m_busy", 32'(dwnld_busy), 32'(m_busy));
      check("m_ovf",  32'(overflow),   32'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [22:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_data = d; ioctl_rom_wr = 1'b1;
    tick();
    ioctl_rom_wr = 1'b0;
  endtask

  task automatic wait_we();
    for (int i = 0; i < 30; i++) begin
      if (prog_we) break;
      tick();
    end
    check("we_timeout", 32'(prog_we), 32'd1);
  endtask

  task automatic commit();
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
  endtask

  task automatic expect_write(input string name, input logic [1:0] b, input logic [21:0] w,
                              input logic [1:0] m, input logic [7:0] d);
    wait_we();
    check({name, "_bank"}, 32'(prog_bank), 32'(b));
    check({name, "_addr"}, 32'(prog_addr), 32'(w));
    check({name, "_mask"}, 32'(prog_mask), 32'(m));
    check({name, "_data"}, 32'(prog_data), 32'(d));
    commit();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; downloading = 1'b0; prog_rdy = 1'b0; ioctl_rom_wr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int quiet;
    do_reset();
    check("rst_we",   32'(prog_we),    32'd0);
    check("rst_mask", 32'(prog_mask),  32'd3);
    check("rst_busy", 32'(dwnld_busy), 32'd0);
    check("rst_ovf",  32'(overflow),   32'd0);
    downloading = 1'b1;
    tick();

    // single byte: strobe in cycle 0, prog_we from cycle 2
    strobe(23'h000003, 8'hA5);
    check("single_we_c1", 32'(prog_we), 32'd0);
    tick();
    check("single_we_c2", 32'(prog_we),   32'd1);
    check("single_addr",  32'(prog_addr), 32'd1);
    check("single_mask",  32'(prog_mask), 32'd1);
    check("single_bank",  32'(prog_bank), 32'd0);
    check("single_data",  32'(prog_data), 32'hA5);
    repeat (4) tick();
    commit();
    check("single_release", 32'(prog_we), 32'd0);
    tick(); tick();

    // bank boundaries
    strobe(23'h0FFFFF, 8'h01);
    expect_write("b0", 2'd0, 22'h07FFFF, 2'b01, 8'h01);
    strobe(23'h100000, 8'h02);
    expect_write("b1", 2'd1, 22'h000000, 2'b10, 8'h02);
    strobe(23'h500001, 8'h03);
    expect_write("b3", 2'd3, 22'h000000, 2'b01, 8'h03);
    strobe(23'h300004, 8'h04);
    expect_write("b2", 2'd2, 22'h000002, 2'b10, 8'h04);

    // overflow: five strobes with prog_rdy held low
    for (int i = 0; i < 5; i++) strobe(23'(i), 8'(8'h11 * (i + 1)));
    check("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++)
      expect_write("ovf_q", 2'd0, 22'(i / 2), (i % 2 == 1) ? 2'b01 : 2'b10, 8'(8'h11 * (i + 1)));
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      if (prog_we) quiet++;
      tick();
    end
    check("ovf_fifth_absent", 32'(quiet), 32'd0);
    downloading = 1'b0; tick();
    downloading = 1'b1; tick();
    check("ovf_clear", 32'(overflow), 32'd0);

    // push while full in the same cycle as a pop
    for (int i = 0; i < 4; i++) strobe(23'(8 + i), 8'(8'hC0 + i));
    wait_we();
    check("full_head", 32'(prog_data), 32'hC0);
    ioctl_addr = 23'd12; ioctl_data = 8'hC4; ioctl_rom_wr = 1'b1; prog_rdy = 1'b1;
    tick();
    ioctl_rom_wr = 1'b0; prog_rdy = 1'b0;
    tick();
    check("full_no_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 5; i++)
      expect_write("full_q", 2'd0, 22'((8 + i) / 2), (i % 2 == 1) ? 2'b01 : 2'b10, 8'(8'hC0 + i));

    // drain after the download ends, prog_rdy 2 cycles after each prog_we
    for (int i = 0; i < 3; i++) strobe(23'h200000 + 23'(i), 8'(8'h70 + i));
    downloading = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_we();
      check("drain_data", 32'(prog_data), 32'(8'h70 + i));
      tick(); tick();
      check("drain_busy", 32'(dwnld_busy), 32'd1);
      commit();
    end
    check("drain_busy_p1", 32'(dwnld_busy), 32'd1);
    tick();
    check("drain_busy_p2", 32'(dwnld_busy), 32'd1);
    tick();
    check("drain_busy_low", 32'(dwnld_busy), 32'd0);

    // reset during WRITE
    downloading = 1'b1;
    strobe(23'h000010, 8'h5A);
    strobe(23'h000011, 8'h5B);
    wait_we();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("rstw_we",   32'(prog_we),   32'd0);
    check("rstw_mask", 32'(prog_mask), 32'd3);
    tick();
    commit();
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      if (prog_we) quiet++;
      tick();
    end
    check("rstw_no_write", 32'(quiet), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ioctl_rom_wr = ($urandom_range(0, 2) == 0);
      ioctl_addr   = 23'($urandom);
      ioctl_data   = 8'($urandom);
      prog_rdy     = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) downloading = ~downloading;
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0; else rst_n = 1'b1;
      tick();
    end
    ioctl_rom_wr = 1'b0; downloading = 1'b0; rst_n = 1'b1; prog_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!dwnld_busy) break;
      tick();
    end
    check("final_idle", 32'(dwnld_busy), 32'd0);
    prog_rdy = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
